uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8-bit UART receiver used in uart_b2b. Samples the serial line at 16x the baud rate and supports configurable data width, stop-bit count and runtime parity mode. Majority-votes each bit and stores received words in an internal FIFO, with per-word parity and frame error flags. Sits between the rx_if serial pin and the CPU-side read port; it is clocked entirely on clk16x.

Parameters:
DATA_BITS, 8, payload bits per frame; legal range 5..9.
STOP_BITS, 1, number of stop bits checked; legal values 1 or 2.
FIFO_DEPTH, 16, number of receive FIFO entries; power of 2, minimum 2.
SYNC_STAGES, 2, number of flops in the rx_in synchroniser; minimum 2.

Ports:
clk16x  in  1  16x-baud oversampling clock; the only clock.
reset  in  1  asynchronous, active-high reset.
rx_in  in  1  serial line; idle high.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
rd_en  in  1  pop the head FIFO entry; ignored when rx_empty=1.
clr_err  in  1  one-cycle pulse that clears the sticky overrun flag.
rx_data  out  DATA_BITS  head FIFO entry (show-ahead).
parity_error  out  1  parity error flag of the head entry.
frame_error  out  1  frame error flag of the head entry.
rx_empty  out  1  FIFO is empty.
rx_full  out  1  FIFO is full.
rx_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
overrun  out  1  sticky flag: a frame was dropped because the FIFO was full.

Behaviour:
- Reset values: rx_data=0, parity_error=0, frame_error=0, rx_empty=1, rx_full=0, rx_count=0, overrun=0. All synchroniser flops reset to 1. FSM resets to IDLE.
- Reset asserted mid-frame: frame is aborted and FIFO contents are discarded.
- Synchroniser: rx_s is rx_in delayed by SYNC_STAGES flops. All decisions below use rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Tick counter: 4-bit, cleared on frame start, wraps every 16 cycles.
- Bit timing: bit n is voted on samples at ticks 7, 8 and 9 of its 16-tick slot. The majority-of-3 decision is made at tick 9.
- Slot numbering: start bit is slot 0; data bits are slots 1..DATA_BITS, LSB first; the parity bit follows; then the stop bit(s).
- IDLE: a 1->0 transition on rx_s enters START. A line held low does not retrigger, so a break produces only one frame.
- START: if the vote is 1, treat as a false start and return to IDLE with no push. If the vote is 0, go to DATA. parity_mode is latched at this decision; mid-frame changes to parity_mode are ignored.
- DATA: shift in DATA_BITS votes.
  - If the latched mode is none, go to STOP after the last data bit.
  - Otherwise go to PARITY.
- PARITY: error if the XOR of data and parity bit is 1 for even mode, or 0 for odd mode.
- STOP: frame_error is set if any checked stop bit votes 0. At the decision of the last stop bit, push {data, parity_err, frame_err} and go to IDLE in the same cycle.
- Push latency: rx_empty falls, and rx_count increments, on the cycle after the push decision.
- Pop: rd_en with rx_empty=0 advances the head. The new head appears on the next cycle.
- Push while full with no pop: the frame is dropped and overrun is set; rx_count is unchanged.
- Push and pop in the same cycle while full: both succeed, count is unchanged, overrun is not set.
- Push and pop in the same cycle while empty: the pop is ignored and the push succeeds.
- Pointer wrap: FIFO pointers wrap modulo FIFO_DEPTH.
- Overrun clearing: overrun clears only on reset or clr_err. If clr_err and a new overrun occur in the same cycle, the set wins.

Decomposition:
- uart_pkg holds:
  - parity_mode_e enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD);
  - rx_state_e enum;
  - OVERSAMPLE=16, SAMPLE_TICK_LO=7, SAMPLE_TICK_HI=9.
- Sub-module uart_sync_fifo: parametrised width and depth, show-ahead read, full/empty/count outputs. Instantiated with width DATA_BITS+2.

Test Plan:
- 8N1 frame 0xA5, no reads → about 10 bit times later rx_empty=0, rx_count=1, rx_data=0xA5, parity_error=0, frame_error=0. rd_en pulse → rx_empty=1 on the next cycle.
- parity_mode=01 (even), frame 0x03 sent with parity bit 1 → rx_data=0x03, parity_error=1. Same data with parity bit 0 → parity_error=0. odd mode with 0x07 and parity bit 0 → parity_error=0.
- 8N1 frame 0x3C with stop bit driven 0, then line held low for 40 bit times → exactly one entry: 0x3C, frame_error=1, rx_count=1.
- rx_in low-pulse of 4 clk16x cycles → false start, no push, rx_count=0. A following 0x81 frame is received correctly.
- FIFO_DEPTH=4, five frames 0x01..0x05 with no reads:
  - after frames 1..4 → rx_count=4, rx_full=1, overrun=0;
  - after frame 5 → overrun=1;
  - draining yields 0x01..0x04;
  - clr_err pulse → overrun=0.
- Reset asserted during data slot 3 of a frame → all outputs at reset values. Next full frame 0x5A is received with rx_count=1 and no error flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and timing constants for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int unsigned OVERSAMPLE     = 16;
  localparam int unsigned TICK_W         = $clog2(OVERSAMPLE);
  localparam int unsigned SAMPLE_TICK_LO = 7;
  localparam int unsigned SAMPLE_TICK_HI = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; writes while full are accepted only alongside a pop.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_param.sv
// 16x-oversampled UART receiver with configurable width/stop bits, runtime parity and receive FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                            clk16x,
  input  logic                            reset,
  input  logic                            rx_in,
  input  logic [1:0]                      parity_mode,
  input  logic                            rd_en,
  input  logic                            clr_err,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            parity_error,
  output logic                            frame_error,
  output logic                            rx_empty,
  output logic                            rx_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            overrun
);

  localparam int unsigned FW = DATA_BITS + 2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s, rx_prev_q;

  rx_state_e              state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic                   s7_q, s7_d, s8_q, s8_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  parity_mode_e           pmode_q, pmode_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d;
  logic                   overrun_q, overrun_d;
  logic                   push, pop_eff, vote, at_hi, par_x;
  logic [FW-1:0]          head;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign vote   = maj3(s7_q, s8_q, rx_s);
  assign at_hi  = (tick_q == TICK_W'(SAMPLE_TICK_HI));
  assign par_x  = (^shift_q) ^ vote;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q + 1'b1;
    s7_d       = s7_q;
    s8_d       = s8_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    pmode_d    = pmode_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    push       = 1'b0;
    if (tick_q == TICK_W'(SAMPLE_TICK_LO))     s7_d = rx_s;
    if (tick_q == TICK_W'(SAMPLE_TICK_LO + 1)) s8_d = rx_s;
    case (state_q)
      IDLE: begin
        // Edge-triggered so a held-low line (break) cannot start a second frame.
        tick_d = '0;
        if (rx_prev_q && !rx_s) state_d = START;
      end
      START: if (at_hi) begin
        if (vote) state_d = IDLE;
        else begin
          state_d   = DATA;
          pmode_d   = parity_mode_e'(parity_mode);
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      DATA: if (at_hi) begin
        shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
          stop_cnt_d = 1'b0;
          state_d    = (pmode_q == PAR_EVEN || pmode_q == PAR_ODD) ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY: if (at_hi) begin
        perr_d  = (pmode_q == PAR_ODD) ? ~par_x : par_x;
        state_d = STOP;
      end
      STOP: if (at_hi) begin
        ferr_d = ferr_q | ~vote;
        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop_eff = rd_en && !rx_empty;

  always_comb begin
    overrun_d = overrun_q;
    if (clr_err) overrun_d = 1'b0;
    if (push && rx_full && !pop_eff) overrun_d = 1'b1;
  end

  always_ff @(posedge clk16x or posedge reset) begin
    if (reset) begin
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      tick_q     <= '0;
      s7_q       <= 1'b1;
      s8_q       <= 1'b1;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      pmode_q    <= PAR_NONE;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      tick_q     <= tick_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      pmode_q    <= pmode_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk16x),
    .rst     (reset),
    .wr_en   (push),
    .wr_data ({shift_q, perr_q, ferr_d}),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  assign rx_data      = head[FW-1:2];
  assign parity_error = head[1];
  assign frame_error  = head[0];
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8-bit frames, 1 stop bit, 4-entry FIFO.
module tb_uart_rx_param;

  logic       clk16x = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [1:0] parity_mode;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       parity_error, frame_error, rx_empty, rx_full, overrun;
  logic [2:0] rx_count;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  uart_rx_param #(
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk16x       (clk16x),
    .reset        (reset),
    .rx_in        (rx_in),
    .parity_mode  (parity_mode),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .rx_data      (rx_data),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .rx_empty     (rx_empty),
    .rx_full      (rx_full),
    .rx_count     (rx_count),
    .overrun      (overrun)
  );

  always #5 clk16x = ~clk16x;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk16x);
  endtask

  task automatic bit_slot(input logic b);
    rx_in = b;
    cycles(16);
  endtask

  // Start bit, 8 data bits LSB first, optional parity, one stop bit; mode_mid applied after the start bit.
  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input logic stop_val, input logic [1:0] mode_mid);
    bit_slot(1'b0);
    parity_mode = mode_mid;
    for (int i = 0; i < 8; i++) bit_slot(d[i]);
    if (par_en) bit_slot(par_bit);
    bit_slot(stop_val);
    if (stop_val) cycles(16);
  endtask

  task automatic pop;
    rd_en = 1'b1;
    cycles(1);
    rd_en = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_data"}, 32'(rx_data), 32'(d));
    check({tag, "_perr"}, 32'(parity_error), 32'(pe));
    check({tag, "_ferr"}, 32'(frame_error), 32'(fe));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data"},  32'(rx_data), 32'h0);
    check({tag, "_perr"},  32'(parity_error), 32'h0);
    check({tag, "_ferr"},  32'(frame_error), 32'h0);
    check({tag, "_empty"}, 32'(rx_empty), 32'h1);
    check({tag, "_full"},  32'(rx_full), 32'h0);
    check({tag, "_count"}, 32'(rx_count), 32'h0);
    check({tag, "_ovr"},   32'(overrun), 32'h0);
  endtask

  initial begin
    reset = 1'b1; rx_in = 1'b1; parity_mode = 2'b00; rd_en = 1'b0; clr_err = 1'b0;
    cycles(4);
    check_reset_state("rst");
    reset = 1'b0;
    cycles(20);
    check_reset_state("post_rst");

    // 8N1 0xA5
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 2'b00);
    check("a5_empty", 32'(rx_empty), 32'h0);
    check("a5_count", 32'(rx_count), 32'h1);
    check_head("a5", 8'hA5, 1'b0, 1'b0);
    pop;
    check("a5_pop_empty", 32'(rx_empty), 32'h1);
    check("a5_pop_count", 32'(rx_count), 32'h0);

    // Even parity: 0x03 has even ones, so parity bit 1 is an error.
    parity_mode = 2'b01;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 2'b01);
    check_head("even_bad", 8'h03, 1'b1, 1'b0);
    pop;
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 2'b01);
    check_head("even_ok", 8'h03, 1'b0, 1'b0);
    pop;
    // Odd parity: 0x07 has three ones, parity bit 0 is correct; mode changed mid-frame is ignored.
    parity_mode = 2'b10;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 2'b00);
    check_head("odd_ok", 8'h07, 1'b0, 1'b0);
    check("odd_count", 32'(rx_count), 32'h1);
    pop;
    parity_mode = 2'b00;

    // Stop bit low, then break for 40 bit times: a single entry only.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 2'b00);
    rx_in = 1'b0;
    cycles(40 * 16);
    rx_in = 1'b1;
    cycles(32);
    check("brk_count", 32'(rx_count), 32'h1);
    check_head("brk", 8'h3C, 1'b0, 1'b1);
    pop;
    check("brk_empty", 32'(rx_empty), 32'h1);

    // Glitch of 4 cycles is a false start.
    rx_in = 1'b0;
    cycles(4);
    rx_in = 1'b1;
    cycles(40);
    check("glitch_count", 32'(rx_count), 32'h0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 2'b00);
    check("f81_count", 32'(rx_count), 32'h1);
    check_head("f81", 8'h81, 1'b0, 1'b0);
    pop;

    // Fill the 4-entry FIFO, then overflow it once.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1, 2'b00);
    check("fill_count", 32'(rx_count), 32'h4);
    check("fill_full",  32'(rx_full), 32'h1);
    check("fill_ovr",   32'(overrun), 32'h0);
    send_frame(8'h05, 1'b0, 1'b0, 1'b1, 2'b00);
    check("ovf_ovr",   32'(overrun), 32'h1);
    check("ovf_count", 32'(rx_count), 32'h4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", 32'(rx_data), 32'(i));
      pop;
    end
    check("drain_empty", 32'(rx_empty), 32'h1);
    check("drain_ovr_sticky", 32'(overrun), 32'h1);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    check("clr_ovr", 32'(overrun), 32'h0);

    // Reset during data slot 3 discards the partial frame and the queued entry.
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 2'b00);
    check("pre_rst_count", 32'(rx_count), 32'h1);
    bit_slot(1'b0);
    bit_slot(1'b0);
    bit_slot(1'b1);
    rx_in = 1'b0;
    cycles(8);
    reset = 1'b1;
    cycles(3);
    check_reset_state("mid_rst");
    rx_in = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(32);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 2'b00);
    check("f5a_count", 32'(rx_count), 32'h1);
    check_head("f5a", 8'h5A, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
